// File: rtl/sop_share_eval.sv
// sop_share_eval: two-stage shared-product SOP evaluator with runtime PLA planes.
// Define SOP_ERR_MON_EN to build in the exp_data error monitor.
module sop_share_eval #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int N_PROD = 4,
  parameter int ET     = 3,
  localparam int CW    = (2*N_IN > N_PROD) ? 2*N_IN : N_PROD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  input  logic [N_OUT-1:0]  exp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_data,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [3:0]        cfg_idx,
  input  logic [CW-1:0]     cfg_data,
  input  logic              mon_clr,
  output logic [15:0]       err_cnt,
  output logic [N_OUT-1:0]  max_err
);

  localparam int LW = 2*N_IN;
  localparam int PW = CW + N_OUT;

  logic [N_PROD-1:0][LW-1:0]    lit_q, lit_d;
  logic [N_OUT-1:0][N_PROD-1:0] act_q, act_d;
  logic [N_OUT-1:0]             oen_q, oen_d;
  logic                         s1_vld_q, s1_vld_d;
  logic [N_PROD-1:0]            s1_prod_q, s1_prod_d;
  logic                         out_vld_q, out_vld_d;
  logic [N_OUT-1:0]             out_q, out_d;

  logic              adv;
  logic [LW-1:0]     lits;
  logic [PW-1:0]     cfg_pad;
  logic [N_PROD-1:0] prod;
  logic [N_OUT-1:0]  sop;

  assign adv       = !out_vld_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_vld_q;
  assign out_data  = out_q;
  assign lits      = {~in_data, in_data};
  assign cfg_pad   = {{N_OUT{1'b0}}, cfg_data};

  wire unused_cfg = ^cfg_pad;

  always_comb begin
    lit_d = lit_q;
    act_d = act_q;
    oen_d = oen_q;
    for (int p = 0; p < N_PROD; p++)
      if (cfg_we && cfg_sel == 2'd0 && int'(cfg_idx) == p)
        lit_d[p] = cfg_pad[LW-1:0];
    for (int o = 0; o < N_OUT; o++)
      if (cfg_we && cfg_sel == 2'd1 && int'(cfg_idx) == o)
        act_d[o] = cfg_pad[N_PROD-1:0];
    if (cfg_we && cfg_sel == 2'd2)
      oen_d = cfg_pad[N_OUT-1:0];
  end

  // Unselected literals read as 1; both polarities of one input give 0.
  always_comb begin
    prod = '0;
    for (int p = 0; p < N_PROD; p++)
      prod[p] = &(lits | ~lit_q[p]);
  end

  // Stage 2 sees this cycle's activation/enable writes (next-state view).
  always_comb begin
    sop = '0;
    for (int o = 0; o < N_OUT; o++)
      sop[o] = oen_d[o] & (|(s1_prod_q & act_d[o]));
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_prod_d = s1_prod_q;
    out_vld_d = out_vld_q;
    out_d     = out_q;
    if (adv) begin
      s1_vld_d  = in_valid;
      out_vld_d = s1_vld_q;
      if (in_valid) s1_prod_d = prod;
      if (s1_vld_q) out_d = sop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lit_q     <= '0;
      act_q     <= '0;
      oen_q     <= '1;
      s1_vld_q  <= 1'b0;
      s1_prod_q <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      lit_q     <= lit_d;
      act_q     <= act_d;
      oen_q     <= oen_d;
      s1_vld_q  <= s1_vld_d;
      s1_prod_q <= s1_prod_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

`ifdef SOP_ERR_MON_EN
  logic [N_OUT-1:0] s1_exp_q, s1_exp_d;
  logic [N_OUT-1:0] s2_exp_q, s2_exp_d;
  logic [N_OUT-1:0] max_q, max_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [N_OUT-1:0] diff;

  always_comb begin
    s1_exp_d = s1_exp_q;
    s2_exp_d = s2_exp_q;
    if (adv) begin
      if (in_valid) s1_exp_d = exp_data;
      if (s1_vld_q) s2_exp_d = s1_exp_q;
    end
    diff = (s2_exp_q > out_q) ? s2_exp_q - out_q
                              : out_q - s2_exp_q;
    cnt_d = cnt_q;
    max_d = max_q;
    if (mon_clr) begin
      cnt_d = '0;
      max_d = '0;
    end else if (out_vld_q && out_ready) begin
      if (int'(diff) > ET && cnt_q != 16'hFFFF)
        cnt_d = cnt_q + 16'd1;
      if (diff > max_q) max_d = diff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_exp_q <= '0;
      s2_exp_q <= '0;
      cnt_q    <= '0;
      max_q    <= '0;
    end else begin
      s1_exp_q <= s1_exp_d;
      s2_exp_q <= s2_exp_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
    end
  end

  assign err_cnt = cnt_q;
  assign max_err = max_q;
`else
  wire unused_mon = ^{exp_data, mon_clr};

  assign err_cnt = '0;
  assign max_err = '0;
`endif

endmodule

// File: tb/tb_sop_share_eval.sv
// tb_sop_share_eval: directed vector table plus stall/reset/config-timing
// sequences for sop_share_eval (monitor checks follow SOP_ERR_MON_EN).
module tb_sop_share_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] exp_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [3:0] cfg_idx;
  logic [7:0] cfg_data;
  logic       mon_clr;
  logic [15:0] err_cnt;
  logic [1:0] max_err;

  int checks = 0;
  int errors = 0;

  logic [1:0] got;
  logic       vld;
  logic [3:0] vq[$];

  always #5 clk = ~clk;

  sop_share_eval #(
    .N_IN(4), .N_OUT(2), .N_PROD(4), .ET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .exp_data(exp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .mon_clr(mon_clr), .err_cnt(err_cnt),
    .max_err(max_err)
  );

  typedef struct {
    logic [3:0] act1;
    logic [1:0] oen;
    logic [3:0] din;
    logic [1:0] dout;
  } vec_t;

  vec_t tbl[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] sel,
                     input logic [3:0] idx,
                     input logic [7:0] dat);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_idx = idx;
    cfg_data = dat;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [3:0] d,
                      input logic [1:0] e,
                      input logic clr,
                      output logic [1:0] g,
                      output logic v);
    in_valid = 1'b1;
    in_data = d;
    exp_data = e;
    tick;
    in_valid = 1'b0;
    tick;
    v = out_valid;
    g = out_data;
    mon_clr = clr;
    tick;
    mon_clr = 1'b0;
  endtask

  // Expected output for the base program: out0=in0&in3, out1 has constant p3.
  function automatic logic [1:0] exp_base(input logic [3:0] x);
    return {1'b1, x[0] & x[3]};
  endfunction

  task automatic run_stream(input int stall, input int exp_cyc);
    int cyc = 0;
    int sent = 0;
    int rcv = 0;
    int n = vq.size();
    bit hv = 0;
    logic [1:0] held = '0;
    logic [1:0] sb[$];
    while (rcv < n && cyc < 40) begin
      out_ready = (cyc >= stall);
      in_valid = (sent < n);
      in_data = (sent < n) ? vq[sent] : 4'd0;
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("stream_extra", 32'd1, 32'd0);
        else chk("stream_data", 32'(out_data), 32'(sb.pop_front()));
        rcv++;
      end else if (out_valid) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (hv) chk("stall_hold", 32'(out_data), 32'(held));
        held = out_data;
        hv = 1;
      end
      if (in_valid && in_ready) begin
        sb.push_back(exp_base(vq[sent]));
        sent++;
      end
      cyc++;
      if (rcv < n) tick;
    end
    chk("stream_count", rcv, n);
    chk("stream_cycles", cyc, exp_cyc);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b1110, 2'b11, 4'h9, 2'b11};
    tbl[1]  = '{4'b1110, 2'b11, 4'h6, 2'b10};
    tbl[2]  = '{4'b1110, 2'b11, 4'h0, 2'b10};
    tbl[3]  = '{4'b1110, 2'b11, 4'hF, 2'b11};
    tbl[4]  = '{4'b0110, 2'b11, 4'h9, 2'b01};
    tbl[5]  = '{4'b0110, 2'b11, 4'h6, 2'b10};
    tbl[6]  = '{4'b0110, 2'b11, 4'h1, 2'b00};
    tbl[7]  = '{4'b0110, 2'b11, 4'hF, 2'b01};
    tbl[8]  = '{4'b0110, 2'b11, 4'h2, 2'b10};
    tbl[9]  = '{4'b1110, 2'b01, 4'h6, 2'b00};
    tbl[10] = '{4'b1110, 2'b01, 4'h9, 2'b01};
    tbl[11] = '{4'b1110, 2'b10, 4'h9, 2'b10};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    exp_data = '0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_sel = '0;
    cfg_idx = '0;
    cfg_data = '0;
    mon_clr = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_max_err", 32'(max_err), 32'd0);

    cfg(2'd0, 4'd0, 8'h09);
    cfg(2'd0, 4'd1, 8'h82);
    cfg(2'd0, 4'd2, 8'h10);
    cfg(2'd0, 4'd3, 8'h00);
    cfg(2'd1, 4'd0, 8'h01);

    foreach (tbl[i]) begin
      cfg(2'd1, 4'd1, {4'b0, tbl[i].act1});
      cfg(2'd2, 4'd0, {6'b0, tbl[i].oen});
      send(tbl[i].din, 2'b00, 1'b0, got, vld);
      chk($sformatf("vec%0d_valid", i), 32'(vld), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(got), 32'(tbl[i].dout));
    end

    cfg(2'd1, 4'd1, 8'h0E);
    cfg(2'd2, 4'd0, 8'h03);

    vq = '{4'h9, 4'h6, 4'h0, 4'h8, 4'h1, 4'hF};
    run_stream(0, 8);
    vq = '{4'h9, 4'h6, 4'hF};
    run_stream(5, 8);

    // Activation write while the sample occupies stage 1.
    in_valid = 1'b1;
    in_data = 4'h9;
    tick;
    in_valid = 1'b0;
    cfg_we = 1'b1;
    cfg_sel = 2'd1;
    cfg_idx = 4'd0;
    cfg_data = 8'h00;
    tick;
    cfg_we = 1'b0;
    chk("act_bypass_valid", 32'(out_valid), 32'd1);
    chk("act_bypass_data", 32'(out_data), 32'd2);
    tick;

    cfg(2'd0, 4'd0, 8'h11);
    cfg(2'd1, 4'd0, 8'h01);
    cfg(2'd1, 4'd1, 8'h00);
    for (int v = 0; v < 16; v++) begin
      send(4'(v), 2'b00, 1'b0, got, vld);
      chk($sformatf("contra_%0d", v), 32'({vld, got}), 32'b100);
    end

    cfg(2'd0, 4'd1, 8'h00);
    cfg(2'd1, 4'd0, 8'h02);
    send(4'h5, 2'b00, 1'b0, got, vld);
    chk("const1_prod", 32'({vld, got}), 32'b101);
    cfg(2'd0, 4'd9, 8'hFF);
    send(4'h5, 2'b00, 1'b0, got, vld);
    chk("lit_idx9_ignored", 32'({vld, got}), 32'b101);
    cfg(2'd3, 4'd1, 8'hFF);
    send(4'h5, 2'b00, 1'b0, got, vld);
    chk("sel3_ignored", 32'({vld, got}), 32'b101);
    cfg(2'd1, 4'd2, 8'h00);
    send(4'h5, 2'b00, 1'b0, got, vld);
    chk("act_idx2_ignored", 32'({vld, got}), 32'b101);

    // Reset with two samples in flight.
    in_valid = 1'b1;
    in_data = 4'h9;
    tick;
    in_data = 4'h6;
    tick;
    in_valid = 1'b0;
    chk("inflight_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    tick;
    chk("midrst_s1_flushed", 32'(out_valid), 32'd0);
    send(4'h9, 2'b00, 1'b0, got, vld);
    chk("postrst_sample", 32'({vld, got}), 32'b100);

`ifdef SOP_ERR_MON_EN
    send(4'h0, 2'd3, 1'b0, got, vld);
    chk("mon_err_cnt_a", 32'(err_cnt), 32'd1);
    chk("mon_max_err_a", 32'(max_err), 32'd3);
    send(4'h0, 2'd1, 1'b0, got, vld);
    chk("mon_err_cnt_b", 32'(err_cnt), 32'd1);
    chk("mon_max_err_b", 32'(max_err), 32'd3);
    mon_clr = 1'b1;
    tick;
    mon_clr = 1'b0;
    chk("mon_clr_cnt", 32'(err_cnt), 32'd0);
    chk("mon_clr_max", 32'(max_err), 32'd0);
    send(4'h0, 2'd3, 1'b1, got, vld);
    chk("mon_clr_xfer_cnt", 32'(err_cnt), 32'd0);
    chk("mon_clr_xfer_max", 32'(max_err), 32'd0);
    send(4'h0, 2'd2, 1'b0, got, vld);
    chk("mon_err_cnt_c", 32'(err_cnt), 32'd1);
    chk("mon_max_err_c", 32'(max_err), 32'd2);
`else
    send(4'h0, 2'd3, 1'b0, got, vld);
    chk("nomon_err_cnt", 32'(err_cnt), 32'd0);
    chk("nomon_max_err", 32'(max_err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sop_share_eval.md
SOP_SHARE_EVAL -- requirements
Module: sop_share_eval

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning number of primary inputs (2..16).
REQ-002 SHALL have parameter N_OUT, default 2, meaning number of outputs (1..8).
REQ-003 SHALL have parameter N_PROD, default 4, meaning number of shared product terms (1..16).
REQ-004 SHALL have parameter ET, default 3, meaning error threshold for the monitor.
REQ-005 SHALL have ports clk, input, 1, clock; rst, input, 1, reset (one clock; reset is synchronous and active-high).
REQ-006 SHALL have ports in_valid, input, 1; in_ready, output, 1; in_data, input, N_IN; exp_data, input, N_OUT (exact reference result for the sample).
REQ-007 SHALL have ports out_valid, output, 1; out_ready, input, 1; out_data, output, N_OUT.
REQ-008 SHALL have config ports cfg_we, input, 1; cfg_sel, input, 2 (0=literal row, 1=activation row, 2=output enable); cfg_idx, input, 4; cfg_data, input, max(2*N_IN, N_PROD).
REQ-009 SHALL have monitor ports mon_clr, input, 1; err_cnt, output, 16; max_err, output, N_OUT.

Function
REQ-010 Literal row p: bit i = positive literal in[i], bit N_IN+i = negated literal ~in[i]; product = AND of selected literals; no literals selected = constant 1; both polarities of one input = constant 0.
REQ-011 Activation row o: bit p set = product p feeds output o; output = OR of activated products; no products activated = 0.
REQ-012 Output enable bit o cleared forces output o to 0.
REQ-013 cfg_we with cfg_idx out of range (>= N_PROD for literal, >= N_OUT for activation) or cfg_sel=3 SHALL be ignored; surplus cfg_data bits ignored.
REQ-014 Pipeline: stage 1 registers N_PROD products, stage 2 registers N_OUT outputs; latency 2 cycles from accepted input to out_valid with no stall.
REQ-015 advance = !out_valid | out_ready; in_ready = advance; both stages move only on advance; a held stage keeps data and valid unchanged.
REQ-016 Input accepted when in_valid & in_ready; stage valid bits propagate bubbles; full throughput one sample per cycle.
REQ-017 A config write in cycle t SHALL affect products for samples accepted at t+1 onward and activation/enable for samples entering stage 2 at t+1 onward; no sample is dropped or duplicated.
REQ-018 out_data stable while out_valid & !out_ready.

Reset
REQ-019 On rst: all stage valid bits 0, out_valid 0, out_data 0, literal rows 0, activation rows 0, output enables all 1, err_cnt 0, max_err 0.
REQ-020 rst mid-stream SHALL discard all in-flight samples; in_ready = 1 on the first cycle after reset release.

Configuration
REQ-021 Macro SOP_ERR_MON_EN SHALL compile the error monitor in or out; ports exist in both builds.
REQ-022 With SOP_ERR_MON_EN: exp_data carried alongside the sample; on each out_valid & out_ready compute d = |exp - out_data| (unsigned, N_OUT bits); d > ET increments err_cnt, saturating at 65535; max_err = max(max_err, d).
REQ-023 With SOP_ERR_MON_EN: mon_clr zeroes err_cnt and max_err; a transfer in the same cycle as mon_clr SHALL NOT be counted.
REQ-024 Without SOP_ERR_MON_EN: exp_data and mon_clr ignored; err_cnt and max_err constant 0; no exp_data pipeline registers.

Verification
REQ-025 Program lit0=in0&in3, lit1=in1&~in3, lit2=~in0, lit3=none; act out0={p0}, out1={p1,p2,p3}; in_data=4'b1001 -> out_data=2'b11 two cycles later; 4'b0110 -> 2'b10.
REQ-026 Same program, out_ready held 0 for 5 cycles with in_valid held 1 -> in_ready 0 after pipeline fills, out_data unchanged, then 3 samples drain in order with none lost.
REQ-027 Literal row with in0 and ~in0 both set, activated on out0 -> out0=0 for all 16 input values; cfg_idx=9 literal write -> no state change.
REQ-028 Monitor build, ET=1 (N_OUT=2): exp=3, out=0 -> err_cnt 1, max_err 3; exp=1, out=0 -> err_cnt unchanged; mon_clr -> both 0.
REQ-029 rst asserted with 2 samples in flight -> out_valid 0 next cycle, out_data 0, activation cleared so post-reset sample yields out_data=0.
REQ-030 Config write of act row 0 in same cycle a sample sits in stage 1 -> that sample's output uses the new activation.
